video_timing_ctrl: RTL and testbench

// - Video timing controller: sequences the horizontal and vertical raster for the HDMI overlay path.
// - Produces hSync, vSync, DE, pixel coordinates and frame/line start strobes.
// - Horizontal phases run ACTIVE -> FRONT -> SYNC -> BACK per line; vertical phases use the same sequence per frame.
// - Replaces free-running per-axis sync generators with a single coherent raster source.

---
 rtl/video_timing_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl
// Coherent raster source for the HDMI overlay path. A horizontal counter
// (hCount) and a vertical counter (vCount) walk the raster; each axis runs
// ACTIVE -> FRONT -> SYNC -> BACK. All outputs are registered and decoded
// from the next counter value, so they describe the same position the
// counters hold after the clock edge.
//
// Optional feature macro: VTC_RUNTIME_CFG_EN
//   Adds a valid/ready port that loads new active sizes. The new sizes take
//   effect on the edge that advances to (0, 0). Porch and sync widths stay
//   fixed by parameters. Without the macro the active sizes are parameters.
//
// Ports
//   clock       in   pixel clock, all logic on posedge
//   reset       in   synchronous reset, active-high, priority over enable
//   enable      in   1 = advance one pixel per clock, 0 = hold (strobes 0)
//   hSyncPulse  out  horizontal sync, asserted level = SYNC_POL
//   vSyncPulse  out  vertical sync, asserted level = SYNC_POL
//   DE          out  data enable, both axes in ACTIVE
//   xPos        out  active column while DE, else 0
//   yPos        out  active line while vertical ACTIVE, else 0
//   lineStart   out  1-cycle strobe when hCount becomes 0
//   frameStart  out  1-cycle strobe when (hCount, vCount) becomes (0, 0)
//   cfgValid    in   (macro only) new-size request
//   cfgReady    out  (macro only) 1 = no size change pending
//   cfgHActive  in   (macro only) requested active pixels per line
//   cfgVActive  in   (macro only) requested active lines per frame
// ---------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int busWidth = 12,
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int SYNC_POL = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                hSyncPulse,
    output logic                vSyncPulse,
    output logic                DE,
    output logic [busWidth-1:0] xPos,
    output logic [busWidth-1:0] yPos,
    output logic                lineStart,
    output logic                frameStart
`ifdef VTC_RUNTIME_CFG_EN
    ,
    input  logic                cfgValid,
    output logic                cfgReady,
    input  logic [busWidth-1:0] cfgHActive,
    input  logic [busWidth-1:0] cfgVActive
`endif
);

    // One extra bit keeps boundary sums (which may reach 2^busWidth) exact.
    localparam int EW = busWidth + 1;

    localparam logic [EW-1:0] H_FP_E      = EW'(H_FP);
    localparam logic [EW-1:0] H_FPS_E     = EW'(H_FP + H_SYNC);
    localparam logic [EW-1:0] H_BLANK_M1  = EW'(H_FP + H_SYNC + H_BP - 1);
    localparam logic [EW-1:0] V_FP_E      = EW'(V_FP);
    localparam logic [EW-1:0] V_FPS_E     = EW'(V_FP + V_SYNC);
    localparam logic [EW-1:0] V_BLANK_M1  = EW'(V_FP + V_SYNC + V_BP - 1);

    localparam logic [busWidth-1:0] H_RST  = busWidth'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [busWidth-1:0] V_RST  = busWidth'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [busWidth-1:0] ONE_B  = busWidth'(1);
    localparam logic                SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [busWidth-1:0] h_cnt_q, h_cnt_d;
    logic [busWidth-1:0] v_cnt_q, v_cnt_d;

    // Sizes of the frame in progress, and sizes in force at the next position
    // (they differ only on the edge that wraps to (0, 0) with a pending load).
    logic [busWidth-1:0] h_act_cur_s, v_act_cur_s;
    logic [busWidth-1:0] h_act_nxt_s, v_act_nxt_s;

    logic [EW-1:0] h_last_s, v_last_s;
    logic          h_wrap_s, v_wrap_s, frame_wrap_s;

    logic          h_in_act_s, v_in_act_s, h_in_sync_s, v_in_sync_s;

    logic                de_q, de_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic [busWidth-1:0] x_q, x_d;
    logic [busWidth-1:0] y_q, y_d;
    logic                ls_q, ls_d;
    logic                fs_q, fs_d;

`ifdef VTC_RUNTIME_CFG_EN
    logic [busWidth-1:0] h_act_q, h_act_d;
    logic [busWidth-1:0] v_act_q, v_act_d;
    logic [busWidth-1:0] pend_h_q, pend_h_d;
    logic [busWidth-1:0] pend_v_q, pend_v_d;
    logic                pend_vld_q, pend_vld_d;
    logic                cfg_rdy_q, cfg_rdy_d;

    // Size handshake: apply pending sizes at the frame wrap, else accept a new request.
    always_comb begin
        h_act_d    = h_act_q;
        v_act_d    = v_act_q;
        pend_h_d   = pend_h_q;
        pend_v_d   = pend_v_q;
        pend_vld_d = pend_vld_q;
        cfg_rdy_d  = cfg_rdy_q;
        if (frame_wrap_s && pend_vld_q) begin
            h_act_d    = pend_h_q;
            v_act_d    = pend_v_q;
            pend_vld_d = 1'b0;
            cfg_rdy_d  = 1'b1;
        end else if (cfgValid && cfg_rdy_q) begin
            pend_h_d   = cfgHActive;
            pend_v_d   = cfgVActive;
            pend_vld_d = 1'b1;
            cfg_rdy_d  = 1'b0;
        end else begin
            cfg_rdy_d  = cfg_rdy_q;
        end
    end

    // Size and pending-request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_act_q    <= busWidth'(H_ACTIVE);
            v_act_q    <= busWidth'(V_ACTIVE);
            pend_h_q   <= '0;
            pend_v_q   <= '0;
            pend_vld_q <= 1'b0;
            cfg_rdy_q  <= 1'b1;
        end else begin
            h_act_q    <= h_act_d;
            v_act_q    <= v_act_d;
            pend_h_q   <= pend_h_d;
            pend_v_q   <= pend_v_d;
            pend_vld_q <= pend_vld_d;
            cfg_rdy_q  <= cfg_rdy_d;
        end
    end

    assign h_act_cur_s = h_act_q;
    assign v_act_cur_s = v_act_q;
    assign h_act_nxt_s = h_act_d;
    assign v_act_nxt_s = v_act_d;
    assign cfgReady    = cfg_rdy_q;
`else
    assign h_act_cur_s = busWidth'(H_ACTIVE);
    assign v_act_cur_s = busWidth'(V_ACTIVE);
    assign h_act_nxt_s = busWidth'(H_ACTIVE);
    assign v_act_nxt_s = busWidth'(V_ACTIVE);
`endif

    assign h_last_s     = {1'b0, h_act_cur_s} + H_BLANK_M1;
    assign v_last_s     = {1'b0, v_act_cur_s} + V_BLANK_M1;
    assign h_wrap_s     = ({1'b0, h_cnt_q} == h_last_s);
    assign v_wrap_s     = ({1'b0, v_cnt_q} == v_last_s);
    assign frame_wrap_s = enable && h_wrap_s && v_wrap_s;

    // Next counter position: hCount wraps at end of line, vCount steps on that wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (enable) begin
            if (h_wrap_s) begin
                h_cnt_d = '0;
                if (v_wrap_s) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + ONE_B;
                end
            end else begin
                h_cnt_d = h_cnt_q + ONE_B;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Phase decode of the next position against the sizes in force there.
    always_comb begin
        h_in_act_s  = ({1'b0, h_cnt_d} <  {1'b0, h_act_nxt_s});
        v_in_act_s  = ({1'b0, v_cnt_d} <  {1'b0, v_act_nxt_s});
        h_in_sync_s = ({1'b0, h_cnt_d} >= ({1'b0, h_act_nxt_s} + H_FP_E)) &&
                      ({1'b0, h_cnt_d} <  ({1'b0, h_act_nxt_s} + H_FPS_E));
        v_in_sync_s = ({1'b0, v_cnt_d} >= ({1'b0, v_act_nxt_s} + V_FP_E)) &&
                      ({1'b0, v_cnt_d} <  ({1'b0, v_act_nxt_s} + V_FPS_E));
    end

    // Output next-state: follow the decode when advancing, otherwise hold with strobes cleared.
    always_comb begin
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        x_d  = x_q;
        y_d  = y_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (enable) begin
            de_d = h_in_act_s && v_in_act_s;
            hs_d = h_in_sync_s ? SYNC_ON : ~SYNC_ON;
            vs_d = v_in_sync_s ? SYNC_ON : ~SYNC_ON;
            x_d  = (h_in_act_s && v_in_act_s) ? h_cnt_d : '0;
            y_d  = v_in_act_s ? v_cnt_d : '0;
            ls_d = h_wrap_s;
            fs_d = frame_wrap_s;
        end else begin
            ls_d = 1'b0;
        end
    end

    // Counter and output registers; reset parks on the last position of the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q <= H_RST;
            v_cnt_q <= V_RST;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hSyncPulse = hs_q;
    assign vSyncPulse = vs_q;
    assign DE         = de_q;
    assign xPos       = x_q;
    assign yPos       = y_q;
    assign lineStart  = ls_q;
    assign frameStart = fs_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_timing_ctrl
// Scoreboard bench for video_timing_ctrl with a small raster (H 8/2/3/1,
// V 4/1/2/1). The driver applies stimulus on the falling edge and pushes the
// expected post-edge outputs, computed from a linear frame index
// (x = p % H_TOTAL, y = p / H_TOTAL). The monitor pops one expectation after
// every rising edge and compares it with the DUT outputs.
// With VTC_RUNTIME_CFG_EN defined the cfg port is also exercised.
// ---------------------------------------------------------------------------
module tb_video_timing_ctrl;

    localparam int BW   = 4;
    localparam int H_A  = 8, H_FP = 2, H_SY = 3, H_BP = 1;
    localparam int V_A  = 4, V_FP = 1, V_SY = 2, V_BP = 1;
    localparam bit SPOL = 1'b1;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        logic          ls;
        logic          fs;
        logic          rdy;
    } obs_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [BW-1:0] cfg_h = '0;
    logic [BW-1:0] cfg_v = '0;
    logic          cfg_ready;
    logic          h_sync, v_sync, de, line_start, frame_start;
    logic [BW-1:0] x_pos, y_pos;

    always #5 clock = ~clock;

    video_timing_ctrl #(
        .busWidth(BW), .H_ACTIVE(H_A), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_A), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP), .SYNC_POL(1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .hSyncPulse(h_sync), .vSyncPulse(v_sync), .DE(de),
        .xPos(x_pos), .yPos(y_pos), .lineStart(line_start), .frameStart(frame_start)
`ifdef VTC_RUNTIME_CFG_EN
        , .cfgValid(cfg_valid), .cfgReady(cfg_ready), .cfgHActive(cfg_h), .cfgVActive(cfg_v)
`endif
    );

`ifndef VTC_RUNTIME_CFG_EN
    assign cfg_ready = 1'b1;
`endif

    // ---------------- reference model ----------------
    int   m_ha = H_A, m_va = V_A;
    int   m_ph = 0, m_pv = 0;
    bit   m_pend = 1'b0;
    int   m_p = 0;
    obs_t m_cur = '0;

    function automatic int m_ht();
        return m_ha + H_FP + H_SY + H_BP;
    endfunction

    function automatic int m_vt();
        return m_va + V_FP + V_SY + V_BP;
    endfunction

    function automatic obs_t decode(input int p);
        obs_t o;
        int x, y;
        x = p % m_ht();
        y = p / m_ht();
        o = '0;
        o.de = (x < m_ha) && (y < m_va);
        o.hs = (x >= m_ha + H_FP && x < m_ha + H_FP + H_SY) ? SPOL : !SPOL;
        o.vs = (y >= m_va + V_FP && y < m_va + V_FP + V_SY) ? SPOL : !SPOL;
        o.x  = o.de ? BW'(x) : '0;
        o.y  = (y < m_va) ? BW'(y) : '0;
        o.ls = (x == 0);
        o.fs = (p == 0);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit cv, input int ch, input int cvv);
        bit xfer;
        xfer = cv && !m_pend;
        if (r) begin
            m_ha   = H_A;
            m_va   = V_A;
            m_pend = 1'b0;
            m_p    = m_ht() * m_vt() - 1;
            m_cur  = '0;
            m_cur.hs = !SPOL;
            m_cur.vs = !SPOL;
        end else begin
            if (e) begin
                if (m_p == m_ht() * m_vt() - 1) begin
                    m_p = 0;
                    if (m_pend) begin
                        m_ha   = m_ph;
                        m_va   = m_pv;
                        m_pend = 1'b0;
                    end
                end else begin
                    m_p = m_p + 1;
                end
                m_cur = decode(m_p);
            end else begin
                m_cur.ls = 1'b0;
                m_cur.fs = 1'b0;
            end
            if (xfer) begin
                m_pend = 1'b1;
                m_ph   = ch;
                m_pv   = cvv;
            end
        end
        m_cur.rdy = !m_pend;
    endtask

    // ---------------- scoreboard ----------------
    obs_t exp_q[$];
    int   n_pushed = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic drive(input bit r, input bit e, input bit cv, input int ch, input int cvv);
        @(negedge clock);
        reset     = r;
        enable    = e;
        cfg_valid = cv;
        cfg_h     = BW'(ch);
        cfg_v     = BW'(cvv);
        model_step(r, e, cv, ch, cvv);
        exp_q.push_back(m_cur);
        n_pushed++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    // Advance until the model sits on (x, y) in the current frame, bounded.
    task automatic run_to(input int x, input int y);
        int guard;
        guard = 0;
        while (((m_p % m_ht()) != x || (m_p / m_ht()) != y) && guard < 300) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0);
            guard++;
        end
    endtask

    // Monitor: one expectation per rising edge, compared 1 time unit after it.
    always @(posedge clock) begin
        obs_t e_v, a_v;
        #1;
        if (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            a_v = '{hs: h_sync, vs: v_sync, de: de, x: x_pos, y: y_pos,
                    ls: line_start, fs: frame_start, rdy: cfg_ready};
`ifndef VTC_RUNTIME_CFG_EN
            a_v.rdy = 1'b0;
            e_v.rdy = 1'b0;
`endif
            n_checks++;
            if (a_v === e_v) begin
                n_pass++;
            end else begin
                $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rdy=%b, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b rdy=%b",
                         $time, a_v.hs, a_v.vs, a_v.de, a_v.x, a_v.y, a_v.ls, a_v.fs, a_v.rdy,
                         e_v.hs, e_v.vs, e_v.de, e_v.x, e_v.y, e_v.ls, e_v.fs, e_v.rdy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // Reset state, then release with enable=1 into (0, 0).
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0, 0);
        run(2 * 112 + 10);

        // Pause for 5 cycles at hCount = 4, then resume.
        run_to(4, 1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
        run(20);

        // Reset mid-frame at line 2, hCount 6, then release.
        run_to(6, 2);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        run(130);

`ifdef VTC_RUNTIME_CFG_EN
        // Mid-frame size load: new width takes effect at the next frame.
        run_to(2, 2);
        drive(1'b0, 1'b1, 1'b1, 6, 4);
        run(3 * 112);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        run(20);
`endif

        // Randomised enable / reset / cfg traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, cv;
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 9) != 0);
`ifdef VTC_RUNTIME_CFG_EN
            cv = ($urandom_range(0, 39) == 0);
`else
            cv = 1'b0;
`endif
            drive(r, e, cv, int'($urandom_range(1, 8)), int'($urandom_range(1, 4)));
        end
        drive(1'b0, 1'b1, 1'b0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #3;
        n_checks++;
        if (n_checks - 1 == n_pushed) begin
            n_pass++;
        end else begin
            $display("FAIL drain: checked %0d expectations, required %0d", n_checks - 1, n_pushed);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
